// File: rtl/clk_skew_tune_pkg.sv
`default_nettype none
// ==== clk_skew_tune_pkg : shared types and decision thresholds for clk_skew_tune_ctrl (rev 1.0) ====
package clk_skew_tune_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    DECIDE = 3'd3,
    LOCKED = 3'd4
  } state_e;

  typedef enum logic {
    SCAN  = 1'b0,
    TRACK = 1'b1
  } mode_e;

  // Scan treats the capture clock as early only on a strict majority; a tie is not early.
  function automatic int majority_thr(input int samples);
    return samples / 2;
  endfunction

  function automatic int track_hi_thr(input int samples);
    return (3 * samples) / 4;
  endfunction

  function automatic int track_lo_thr(input int samples);
    return samples / 4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_skew_tune_ctrl_phase_sample_accum.sv
`default_nettype none
// ==== phase_sample_accum : counts qualified phase samples and early votes for one decision (rev 1.0) ====
module phase_sample_accum #(
  parameter int SAMPLES = 8,
  parameter int CNT_W   = $clog2(SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             phase_valid,
  input  logic             phase_early,
  output logic [CNT_W-1:0] early_cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(SAMPLES - 1);

  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] early_cnt_q, early_cnt_d;

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    early_cnt_d  = early_cnt_q;
    if (clear) begin
      sample_cnt_d = '0;
      early_cnt_d  = '0;
    end else if (phase_valid) begin
      sample_cnt_d = sample_cnt_q + CNT_W'(1);
      if (phase_early) early_cnt_d = early_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt_q <= '0;
      early_cnt_q  <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      early_cnt_q  <= early_cnt_d;
    end
  end

  // Fires on the cycle the last sample arrives so the decision follows immediately.
  assign done      = !clear && phase_valid && (sample_cnt_q == LAST_SAMPLE);
  assign early_cnt = early_cnt_q;

endmodule
`default_nettype wire

// File: rtl/clk_skew_tune_ctrl.sv
`default_nettype none
// ==== clk_skew_tune_ctrl : scan/track calibration controller for the capture-clock delay line (rev 1.0) ====
module clk_skew_tune_ctrl
  import clk_skew_tune_pkg::*;
#(
  parameter int NUM_TAPS       = 8,
  parameter int TAP_W          = $clog2(NUM_TAPS),
  parameter int SETTLE_CYC     = 4,
  parameter int SAMPLES        = 8,
  parameter bit TRACK_EN       = 1'b1,
  parameter int TRACK_INTERVAL = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             phase_valid,
  input  logic             phase_early,
  output logic [TAP_W-1:0] tap_sel,
  output logic             busy,
  output logic             locked,
  output logic             cal_fail
);

  localparam int SMP_W = $clog2(SAMPLES + 1);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int INT_W = $clog2(TRACK_INTERVAL + 1);

  localparam logic [TAP_W-1:0] TAP_MAX     = TAP_W'(NUM_TAPS - 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [INT_W-1:0] INT_LAST    = INT_W'(TRACK_INTERVAL - 1);
  localparam logic [SMP_W-1:0] MAJ_THR     = SMP_W'(majority_thr(SAMPLES));
  localparam logic [SMP_W-1:0] HI_THR      = SMP_W'(track_hi_thr(SAMPLES));
  localparam logic [SMP_W-1:0] LO_THR      = SMP_W'(track_lo_thr(SAMPLES));

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic             locked_q, locked_d;
  logic             cal_fail_q, cal_fail_d;
  logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [INT_W-1:0] interval_cnt_q, interval_cnt_d;

  logic             acc_clear;
  logic             acc_valid;
  logic             acc_done;
  logic [SMP_W-1:0] early_cnt;

  // Counts are held through DECIDE and zeroed everywhere else, so every entry to SAMPLE starts clean.
  assign acc_clear = (state_q != SAMPLE) && (state_q != DECIDE);
  assign acc_valid = phase_valid && (state_q == SAMPLE);

  phase_sample_accum #(
    .SAMPLES (SAMPLES),
    .CNT_W   (SMP_W)
  ) u_accum (
    .clk         (clk),
    .rst         (rst),
    .clear       (acc_clear),
    .phase_valid (acc_valid),
    .phase_early (phase_early),
    .early_cnt   (early_cnt),
    .done        (acc_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      mode_q         <= SCAN;
      tap_q          <= '0;
      locked_q       <= 1'b0;
      cal_fail_q     <= 1'b0;
      settle_cnt_q   <= '0;
      interval_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      tap_q          <= tap_d;
      locked_q       <= locked_d;
      cal_fail_q     <= cal_fail_d;
      settle_cnt_q   <= settle_cnt_d;
      interval_cnt_q <= interval_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    mode_d         = mode_q;
    tap_d          = tap_q;
    locked_d       = locked_q;
    cal_fail_d     = cal_fail_q;
    settle_cnt_d   = '0;
    interval_cnt_d = '0;
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      locked_d   = 1'b0;
      cal_fail_d = 1'b0;
    end else if (start && !abort && !busy) begin
      state_d    = SETTLE;
      mode_d     = SCAN;
      tap_d      = '0;
      locked_d   = 1'b0;
      cal_fail_d = 1'b0;
    end else begin
      case (state_q)
        SETTLE: begin
          // A tracking nudge only needs the line to settle; it resumes LOCKED without re-sampling.
          if (settle_cnt_q == SETTLE_LAST) state_d = (mode_q == TRACK) ? LOCKED : SAMPLE;
          else settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
        SAMPLE: begin
          if (acc_done) state_d = DECIDE;
        end
        DECIDE: begin
          if (mode_q == SCAN) begin
            if (early_cnt > MAJ_THR) begin
              if (tap_q != TAP_MAX) begin
                tap_d   = tap_q + TAP_W'(1);
                state_d = SETTLE;
              end else begin
                cal_fail_d = 1'b1;
                state_d    = IDLE;
              end
            end else begin
              locked_d = 1'b1;
              state_d  = LOCKED;
            end
          end else begin
            if ((early_cnt >= HI_THR) && (tap_q != TAP_MAX)) begin
              tap_d   = tap_q + TAP_W'(1);
              state_d = SETTLE;
            end else if ((early_cnt <= LO_THR) && (tap_q != '0)) begin
              tap_d   = tap_q - TAP_W'(1);
              state_d = SETTLE;
            end else begin
              state_d = LOCKED;
            end
          end
        end
        LOCKED: begin
          if (TRACK_EN) begin
            if (interval_cnt_q == INT_LAST) begin
              state_d = SAMPLE;
              mode_d  = TRACK;
            end else begin
              interval_cnt_d = interval_cnt_q + INT_W'(1);
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    busy     = (state_q == SETTLE) || (state_q == SAMPLE) || (state_q == DECIDE);
    tap_sel  = tap_q;
    locked   = locked_q;
    cal_fail = cal_fail_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_skew_tune_ctrl.sv
`default_nettype none
// ==== tb_clk_skew_tune_ctrl : directed self-checking bench for clk_skew_tune_ctrl (rev 1.0) ====
module tb_clk_skew_tune_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       phase_valid;
  logic       phase_early;
  logic [2:0] tap_sel;
  logic       busy;
  logic       locked;
  logic       cal_fail;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clk_skew_tune_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .phase_valid (phase_valid),
    .phase_early (phase_early),
    .tap_sel     (tap_sel),
    .busy        (busy),
    .locked      (locked),
    .cal_fail    (cal_fail)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    phase_valid = 1'b0;
    phase_early = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Valid sample every cycle; capture clock reads early while tap_sel < early_below.
  task automatic scan_run(input int early_below, input int max_cyc, output int n, output logic prev_busy);
    n = 0;
    prev_busy = 1'b0;
    phase_valid = 1'b1;
    while (!(locked || cal_fail) && n < max_cyc) begin
      phase_early = (int'(tap_sel) < early_below);
      prev_busy = busy;
      tick();
      n++;
    end
    phase_valid = 1'b0;
    phase_early = 1'b0;
  endtask

  int lock_drop = 0;

  task automatic track_check(input string tag, input int n_early, input int exp_tap, input int exp_busy_cyc);
    int n;
    n = 0;
    phase_valid = 1'b0;
    while (!busy && n < 200) begin
      tick();
      n++;
      if (!locked) lock_drop++;
    end
    check_val({tag, "_interval"}, n, 64);
    for (int i = 0; i < 8; i++) begin
      phase_valid = 1'b1;
      phase_early = (i < n_early);
      tick();
      if (!locked) lock_drop++;
    end
    phase_valid = 1'b0;
    phase_early = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
      if (!locked) lock_drop++;
    end
    check_val({tag, "_busy_cyc"}, n, exp_busy_cyc);
    check_val({tag, "_tap"}, tap_sel, exp_tap);
    check_val({tag, "_locked"}, locked, 1);
  endtask

  initial begin
    int   n;
    int   nvalid;
    int   j;
    logic pb;

    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    phase_valid = 1'b0;
    phase_early = 1'b0;
    tick();
    tick();
    check_val("rst_tap", tap_sel, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_locked", locked, 0);
    check_val("rst_cal_fail", cal_fail, 0);
    rst = 1'b0;
    tick();

    // Scan: early on taps 0..2, lock on tap 3 after 4*13 cycles.
    do_start();
    check_val("start_busy", busy, 1);
    check_val("start_tap", tap_sel, 0);
    scan_run(3, 200, n, pb);
    check_val("scan_cycles", n, 52);
    check_val("scan_tap", tap_sel, 3);
    check_val("scan_locked", locked, 1);
    check_val("scan_busy_after", busy, 0);
    check_val("scan_busy_before", pb, 1);

    // Tracking from tap 3: up on 7/8, hold on 4/8, down on 1/8.
    track_check("trk_up", 7, 4, 5);
    track_check("trk_hold", 4, 4, 1);
    track_check("trk_down", 1, 3, 5);
    check_val("trk_lock_drop", lock_drop, 0);

    // Abort during SAMPLE at tap 2 with a simultaneous start.
    do_start();
    phase_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      phase_early = (int'(tap_sel) < 5);
      tick();
    end
    check_val("pre_abort_tap", tap_sel, 2);
    check_val("pre_abort_busy", busy, 1);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check_val("abort_busy", busy, 0);
    check_val("abort_tap", tap_sel, 2);
    check_val("abort_locked", locked, 0);
    check_val("abort_cal_fail", cal_fail, 0);
    repeat (3) tick();
    check_val("abort_stays_idle", busy, 0);
    check_val("abort_tap_hold", tap_sel, 2);
    phase_valid = 1'b0;
    phase_early = 1'b0;

    // SETTLE pulses ignored; gapped SAMPLE; 4/8 tie locks on tap 0.
    do_start();
    n = 0;
    nvalid = 0;
    pb = 1'b0;
    while (!locked && n < 80) begin
      if (n < 4) begin
        phase_valid = 1'b1;
        phase_early = 1'b1;
      end else begin
        j = n - 4;
        phase_valid = ((j % 3) == 2);
        phase_early = phase_valid && (nvalid < 4);
        if (phase_valid) nvalid++;
      end
      pb = busy;
      tick();
      n++;
    end
    phase_valid = 1'b0;
    phase_early = 1'b0;
    check_val("gap_cycles", n, 29);
    check_val("gap_tap", tap_sel, 0);
    check_val("gap_busy_before", pb, 1);

    // Always early: scan exhausts all taps and fails.
    do_start();
    scan_run(100, 300, n, pb);
    check_val("fail_cycles", n, 104);
    check_val("fail_cal_fail", cal_fail, 1);
    check_val("fail_tap", tap_sel, 7);
    check_val("fail_locked", locked, 0);
    check_val("fail_busy", busy, 0);

    // Restart clears cal_fail; asynchronous reset mid-SAMPLE at tap 5.
    do_start();
    check_val("restart_cal_fail", cal_fail, 0);
    phase_valid = 1'b1;
    for (int i = 0; i < 71; i++) begin
      phase_early = (int'(tap_sel) < 6);
      tick();
    end
    check_val("pre_rst_tap", tap_sel, 5);
    check_val("pre_rst_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_tap", tap_sel, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_locked", locked, 0);
    check_val("arst_cal_fail", cal_fail, 0);
    phase_valid = 1'b0;
    phase_early = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_skew_tune_ctrl.md
Name: clk_skew_tune_ctrl

Overview:
Calibration and tracking controller for the programmable clock-path delay line feeding the capture flops.
- Drives the delay-line tap select.
- Samples a phase detector that compares launch and capture clock edges.
- Scans taps upward until the capture clock is no longer early, then locks.
- Optionally re-checks the lock periodically and nudges the tap by ±1.

Parameters:
NUM_TAPS, 8, number of delay-line taps (≥2)
TAP_W, $clog2(NUM_TAPS), tap select width (derived)
SETTLE_CYC, 4, cycles to wait after any tap change before sampling
SAMPLES, 8, valid phase samples per decision (even, ≥4)
TRACK_EN, 1, enable periodic tracking in LOCKED
TRACK_INTERVAL, 64, LOCKED cycles between tracking checks

Ports:
clk  in  1  block clock
rst  in  1  reset, asynchronous, active-high
start  in  1  single-cycle calibration request
abort  in  1  single-cycle abort request
phase_valid  in  1  phase detector result valid this cycle
phase_early  in  1  capture clock early (qualified by phase_valid)
tap_sel  out  TAP_W  delay-line tap select
busy  out  1  calibration or tracking in progress
locked  out  1  tap calibrated and in use
cal_fail  out  1  scan reached max tap without lock (sticky until next start)

Behaviour:
- Reset: tap_sel=0, busy=0, locked=0, cal_fail=0, state=IDLE, all counters 0. Reset mid-operation returns to IDLE immediately.
- States: IDLE, SETTLE, SAMPLE, DECIDE, LOCKED. Mode flag is SCAN or TRACK.
- IDLE:
  - start → next cycle tap_sel=0, cal_fail=0, locked=0, mode=SCAN, go to SETTLE.
  - busy=1 in SETTLE, SAMPLE and DECIDE; 0 otherwise.
- SETTLE:
  - Counts exactly SETTLE_CYC cycles, then goes to SAMPLE.
  - phase_valid is ignored.
  - Sample and early counters are cleared on entry.
- SAMPLE:
  - Each phase_valid cycle increments sample_cnt; also increments early_cnt when phase_early=1.
  - Non-valid cycles stall; there is no timeout.
  - When sample_cnt reaches SAMPLES, go to DECIDE next cycle.
- DECIDE, SCAN mode (one cycle):
  - early_cnt > SAMPLES/2 means early. A tie counts as not early.
  - Early and tap_sel < NUM_TAPS-1 → tap_sel+1, go to SETTLE.
  - Early and tap_sel = NUM_TAPS-1 → cal_fail=1, go to IDLE. tap_sel holds max; locked stays 0.
  - Not early → locked=1, go to LOCKED. tap_sel holds.
- LOCKED:
  - With TRACK_EN=1, an interval counter runs. At TRACK_INTERVAL cycles it resets, sets mode=TRACK, and goes to SAMPLE with tap unchanged. locked stays 1.
  - With TRACK_EN=0, stays in LOCKED indefinitely.
- DECIDE, TRACK mode:
  - early_cnt ≥ 3·SAMPLES/4 and tap<max → tap+1.
  - early_cnt ≤ SAMPLES/4 and tap>0 → tap−1.
  - Otherwise hold; saturate at both ends (no wrap).
  - Tap changed → SETTLE, then back to LOCKED (not SAMPLE).
  - Tap unchanged → LOCKED directly.
  - locked remains 1 throughout tracking.
- Priority within a cycle: rst > abort > start > FSM.
- abort (any non-IDLE state) → next cycle IDLE. locked=0, cal_fail=0, tap_sel holds its current value.
- start while busy is ignored. start in LOCKED or IDLE restarts a scan.
- tap_sel changes only on DECIDE or start, never mid-SETTLE or mid-SAMPLE.
- Counter widths:
  - Sample and early counters: $clog2(SAMPLES+1).
  - Settle counter: $clog2(SETTLE_CYC+1).
  - Interval counter: $clog2(TRACK_INTERVAL+1).

Decomposition:
- Package clk_skew_tune_pkg holds:
  - the state enum (IDLE, SETTLE, SAMPLE, DECIDE, LOCKED);
  - the mode enum (SCAN, TRACK);
  - threshold helper functions (majority, high and low tracking thresholds).
- Sub-module phase_sample_accum (clear, phase_valid, phase_early → sample_cnt, early_cnt, done) is natural.
- FSM and tap register remain in the top module.

Test Plan:
1. Reset mid-SAMPLE at tap 5: assert rst asynchronously → tap_sel=0, busy=0, locked=0, cal_fail=0 without waiting for a clk edge.
2. Defaults, phase_valid=1 every cycle. phase_early=1 for taps 0–2, 0 from tap 3 → locked=1 with tap_sel=3. busy drops the same cycle locked rises. Each tap costs 4 settle + 8 sample + 1 decide cycles.
3. phase_early=1 constantly → cal_fail=1, tap_sel=7, locked=0, busy=0.
4. Locked at tap 3, TRACK_EN=1:
   - after 64 cycles feed 7/8 early → tap_sel=4, locked stays 1;
   - next check 4/8 early → tap holds 4;
   - next check 1/8 early → tap_sel=3.
5. abort during SAMPLE at tap 2 → IDLE next cycle, tap_sel=2, busy=0. A simultaneous start with abort is ignored.
6. phase_valid pulses during SETTLE plus gapped phase_valid in SAMPLE (every 3rd cycle) → SETTLE pulses not counted; decision only after exactly 8 valid samples.
